// File: rtl/mem_pkg.sv
// Shared defaults, derived widths and address decode helpers for the banked RAM.
// Bank index comes from the low address bits; the row is the rest of the in-range address.
package mem_pkg;

    localparam int DATA_W_DEF    = 128;
    localparam int DEPTH_DEF     = 1024;
    localparam int NUM_RD_DEF    = 8;
    localparam int NUM_BANKS_DEF = 4;

    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF) + 1;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;
    localparam int BANK_W_DEF = $clog2(NUM_BANKS_DEF);
    localparam int ROW_W_DEF  = ADDR_W_DEF - 1 - BANK_W_DEF;

    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_w);
        return addr & ((32'd1 << bank_w) - 32'd1);
    endfunction

    // The top address bit only flags out-of-range, so it is masked off before the row shift
    function automatic logic [31:0] row_of(input logic [31:0] addr, input int depth, input int bank_w);
        return (addr & (32'(depth) - 32'd1)) >> bank_w;
    endfunction

endpackage

// File: rtl/banked_ram_if.sv
// Write port and multi-port read bus of the banked RAM.
interface banked_ram_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);
    localparam int BE_W = DATA_W / 8;

    logic                             wr_en;
    logic [ADDR_W-1:0]                wr_addr;
    logic [DATA_W-1:0]                wr_data;
    logic [BE_W-1:0]                  wr_be;
    logic                             wr_err;
    logic [NUM_RD-1:0]                rd_req;
    logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0]                rd_gnt;
    logic [NUM_RD-1:0]                rd_vld;
    logic [NUM_RD-1:0][DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]                rd_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr,
        input  wr_err, rd_gnt, rd_vld, rd_data, rd_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr,
        output wr_err, rd_gnt, rd_vld, rd_data, rd_err
    );

endinterface

// File: rtl/banked_ram_rr_arb.sv
// Per-bank round-robin arbiter: one-hot grant, pointer moves past the winner only on a grant.
module rr_arb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] win_s;
    logic [PTR_W-1:0] idx_s;
    logic [N-1:0]     gnt_s;
    logic             found_s;

    // Scan ports starting at the pointer and grant the first requester
    always_comb begin
        gnt_s   = '0;
        win_s   = ptr_r;
        idx_s   = ptr_r;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s = PTR_W'((int'(ptr_r) + i) % N);
            if (en && !found_s && req[idx_s]) begin
                gnt_s[idx_s] = 1'b1;
                win_s        = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer register: next priority goes to the port after the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= (win_s == PTR_W'(N - 1)) ? '0 : win_s + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/banked_ram.sv
// Multi-port banked RAM: one write port with absolute bank priority, NUM_RD read ports
// arbitrated round-robin per bank, one-cycle read latency, out-of-range detection.
module banked_ram
    import mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_RD    = NUM_RD_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF
) (
    input logic        clk,
    input logic        rst,
    banked_ram_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH) + 1;
    localparam int BE_W   = DATA_W / 8;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - 1 - BANK_W;
    localparam int ROWS   = DEPTH / NUM_BANKS;

    logic                            wr_ok_s;
    logic                            wr_oor_s;
    logic [BANK_W-1:0]               wr_bank_s;
    logic [ROW_W-1:0]                wr_row_s;
    logic [NUM_RD-1:0]               rd_oor_s;
    logic [NUM_RD-1:0][BANK_W-1:0]   rd_bank_s;
    logic [NUM_RD-1:0][ROW_W-1:0]    rd_row_s;
    logic [NUM_BANKS-1:0][NUM_RD-1:0] bank_req_s;
    logic [NUM_BANKS-1:0][NUM_RD-1:0] bank_gnt_s;
    logic [NUM_BANKS-1:0]            bank_we_s;
    logic [NUM_BANKS-1:0]            bank_free_s;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_q_s;
    logic [NUM_RD-1:0]               gnt_s;
    logic [NUM_RD-1:0][DATA_W-1:0]   data_s;
    logic [NUM_RD-1:0]               vld_r;
    logic [NUM_RD-1:0]               err_r;
    logic [NUM_RD-1:0][BANK_W-1:0]   src_bank_r;
    logic [NUM_RD-1:0][DATA_W-1:0]   hold_r;
    logic                            wr_err_r;

    // Address decode for the write port and every read port
    always_comb begin
        wr_oor_s  = (bus.wr_addr >= ADDR_W'(DEPTH));
        wr_ok_s   = bus.wr_en && !wr_oor_s && !rst;
        wr_bank_s = BANK_W'(bank_of(32'(bus.wr_addr), BANK_W));
        wr_row_s  = ROW_W'(row_of(32'(bus.wr_addr), DEPTH, BANK_W));
        for (int p = 0; p < NUM_RD; p++) begin
            rd_oor_s[p]  = (bus.rd_addr[p] >= ADDR_W'(DEPTH));
            rd_bank_s[p] = BANK_W'(bank_of(32'(bus.rd_addr[p]), BANK_W));
            rd_row_s[p]  = ROW_W'(row_of(32'(bus.rd_addr[p]), DEPTH, BANK_W));
        end
    end

    // A bank written this cycle is closed to readers; reads only request their own bank
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we_s[b]   = wr_ok_s && (wr_bank_s == BANK_W'(b));
            bank_free_s[b] = !rst && !bank_we_s[b];
            for (int p = 0; p < NUM_RD; p++) begin
                bank_req_s[b][p] = bus.rd_req[p] && !rd_oor_s[p] && (rd_bank_s[p] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_RD-1:0] gnt_b;
        logic [ROW_W-1:0]  rd_row_b;
        logic [DATA_W-1:0] q_r;
        logic [DATA_W-1:0] mem_r [ROWS];

        rr_arb #(.N(NUM_RD)) u_arb (
            .clk (clk),
            .rst (rst),
            .en  (bank_free_s[b]),
            .req (bank_req_s[b]),
            .gnt (gnt_b)
        );

        // Row of the single granted reader (grant is one-hot)
        always_comb begin
            rd_row_b = '0;
            for (int p = 0; p < NUM_RD; p++) begin
                rd_row_b = rd_row_b | ({ROW_W{gnt_b[p]}} & rd_row_s[p]);
            end
        end

        // Single-port bank: byte-masked write, otherwise registered read
        always_ff @(posedge clk) begin
            if (bank_we_s[b]) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (bus.wr_be[k]) begin
                        mem_r[wr_row_s][k*8 +: 8] <= bus.wr_data[k*8 +: 8];
                    end
                end
            end else if (|gnt_b) begin
                q_r <= mem_r[rd_row_b];
            end
        end

        assign bank_gnt_s[b] = gnt_b;
        assign bank_q_s[b]   = q_r;
    end

    // Out-of-range reads are granted without a bank
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            gnt_s[p] = !rst && bus.rd_req[p] && rd_oor_s[p];
            for (int b = 0; b < NUM_BANKS; b++) begin
                gnt_s[p] = gnt_s[p] | bank_gnt_s[b][p];
            end
        end
    end

    // Per-port response stage; remembers which bank will deliver the data
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r      <= '0;
            err_r      <= '0;
            src_bank_r <= '0;
            hold_r     <= '0;
            wr_err_r   <= 1'b0;
        end else begin
            vld_r      <= gnt_s;
            err_r      <= gnt_s & rd_oor_s;
            src_bank_r <= rd_bank_s;
            hold_r     <= data_s;
            wr_err_r   <= bus.wr_en && wr_oor_s;
        end
    end

    // Read data mux: fresh bank output on valid, zero on error, last value otherwise
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            if (rst) begin
                data_s[p] = '0;
            end else if (vld_r[p]) begin
                data_s[p] = err_r[p] ? '0 : bank_q_s[src_bank_r[p]];
            end else begin
                data_s[p] = hold_r[p];
            end
        end
    end

    assign bus.rd_gnt  = gnt_s;
    assign bus.rd_vld  = vld_r & {NUM_RD{!rst}};
    assign bus.rd_err  = err_r & {NUM_RD{!rst}};
    assign bus.rd_data = data_s;
    assign bus.wr_err  = wr_err_r && !rst;

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram: a word-array reference model predicts grants and read
// responses; a separate monitor checks every response the DUT presents.
module tb_banked_ram;
    localparam int DW    = 128;
    localparam int DEPTH = 1024;
    localparam int NR    = 8;
    localparam int NB    = 4;
    localparam int AW    = 11;
    localparam int BEW   = 16;
    localparam int PRE   = 64;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_ram_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    banked_ram #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_BANKS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          exp_q [NR][$];
    logic [DW-1:0] last_m [NR];
    logic [DW-1:0] mem_m [DEPTH];
    int            ptr_m [NB];
    logic [NR-1:0] gnt_m = '0;
    logic          exp_wr_err = 1'b0;
    int            errors = 0;
    int            checks = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: sample inputs mid-cycle, predict grants, queue the expected responses
    initial begin
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        forever begin
            @(negedge clk);
            #1;
            gnt_m = '0;
            if (rst) begin
                for (int b = 0; b < NB; b++) ptr_m[b] = 0;
                exp_wr_err = 1'b0;
            end else begin
                int   wb;
                int   wa;
                exp_t e;
                wa = int'(bus.wr_addr);
                wb = (bus.wr_en && wa < DEPTH) ? (wa % NB) : -1;
                for (int p = 0; p < NR; p++) begin
                    if (bus.rd_req[p] && int'(bus.rd_addr[p]) >= DEPTH) begin
                        gnt_m[p] = 1'b1;
                        e.err = 1'b1;
                        e.data = '0;
                        exp_q[p].push_back(e);
                    end
                end
                for (int b = 0; b < NB; b++) begin
                    int win;
                    win = -1;
                    for (int k = 0; k < NR; k++) begin
                        int p;
                        int a;
                        p = (ptr_m[b] + k) % NR;
                        a = int'(bus.rd_addr[p]);
                        if (win < 0 && bus.rd_req[p] && a < DEPTH && (a % NB) == b) win = p;
                    end
                    if (b != wb && win >= 0) begin
                        gnt_m[win] = 1'b1;
                        ptr_m[b] = (win + 1) % NR;
                        e.err = 1'b0;
                        e.data = mem_m[int'(bus.rd_addr[win])];
                        exp_q[win].push_back(e);
                    end
                end
                if (wb >= 0) begin
                    for (int k = 0; k < BEW; k++) begin
                        if (bus.wr_be[k]) mem_m[wa][k*8 +: 8] = bus.wr_data[k*8 +: 8];
                    end
                end
                exp_wr_err = bus.wr_en && (wa >= DEPTH);
            end
            chk("rd_gnt", DW'(bus.rd_gnt), DW'(gnt_m));
        end
    end

    // Monitor: compare what the DUT presents against the queued expectations
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rd_vld", DW'(bus.rd_vld), '0);
                chk("rst_rd_err", DW'(bus.rd_err), '0);
                chk("rst_wr_err", DW'(bus.wr_err), '0);
                for (int p = 0; p < NR; p++) begin
                    chk($sformatf("rst_rd_data[%0d]", p), bus.rd_data[p], '0);
                    exp_q[p].delete();
                    last_m[p] = '0;
                end
            end else begin
                chk("wr_err", DW'(bus.wr_err), DW'(exp_wr_err));
                for (int p = 0; p < NR; p++) begin
                    logic ev;
                    exp_t e;
                    ev = (exp_q[p].size() != 0);
                    chk($sformatf("rd_vld[%0d]", p), DW'(bus.rd_vld[p]), DW'(ev));
                    if (ev) begin
                        e = exp_q[p].pop_front();
                        if (bus.rd_vld[p]) begin
                            chk($sformatf("rd_err[%0d]", p), DW'(bus.rd_err[p]), DW'(e.err));
                            chk($sformatf("rd_data[%0d]", p), bus.rd_data[p], e.data);
                            last_m[p] = e.data;
                        end
                    end else begin
                        chk($sformatf("rd_hold[%0d]", p), bus.rd_data[p], last_m[p]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be   = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        bus.wr_be   = be;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rd_req[p]  = 1'b1;
        bus.rd_addr[p] = AW'(a);
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int rand_addr();
        if ($urandom_range(31, 0) == 0) return DEPTH + int'($urandom_range(DEPTH - 1, 0));
        return int'($urandom_range(PRE - 1, 0));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // Stimulus: preload, directed scenarios, then randomized traffic with a mid-burst reset
    initial begin
        idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int a = 0; a < PRE; a++) begin
            wr(a, rand_data(), 16'hFFFF);
            tick();
        end
        idle();
        tick();

        wr(5, {16{8'hA5}}, 16'hFFFF);
        tick();
        idle();
        set_rd(0, 5);
        tick();
        idle();
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_rd(0, 1);
        set_rd(1, 5);
        set_rd(2, 9);
        set_rd(3, 13);
        repeat (4) tick();
        idle();
        tick();

        for (int p = 0; p < 4; p++) set_rd(p, p);
        tick();
        idle();
        tick();

        wr(8, rand_data(), 16'hFFFF);
        set_rd(2, 8);
        tick();
        bus.wr_en = 1'b0;
        tick();
        idle();
        tick();

        set_rd(7, DEPTH);
        wr(DEPTH + 3, rand_data(), 16'hFFFF);
        tick();
        idle();
        set_rd(0, 3);
        tick();
        idle();
        tick();

        wr(10, {DW{1'b1}}, 16'hFFFF);
        tick();
        wr(10, rand_data(), 16'h0001);
        tick();
        idle();
        set_rd(1, 10);
        tick();
        idle();
        tick();

        for (int c = 0; c < 1500; c++) begin
            rst = (c == 700 || c == 701);
            bus.wr_en   = 1'($urandom_range(1, 0));
            bus.wr_addr = AW'(rand_addr());
            bus.wr_data = rand_data();
            bus.wr_be   = BEW'($urandom);
            for (int p = 0; p < NR; p++) begin
                if (!(bus.rd_req[p] && !gnt_m[p])) begin
                    bus.rd_req[p]  = ($urandom_range(2, 0) != 0);
                    bus.rd_addr[p] = AW'(rand_addr());
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (3) tick();
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
